// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: scalar opcodes, ctrl bundle
// bit layout, FSM state encoding and a helper that packs a ctrl word.
package ctrl_pkg;

  localparam logic [4:0] OPC_AND  = 5'b00000;
  localparam logic [4:0] OPC_OR   = 5'b00001;
  localparam logic [4:0] OPC_XOR  = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_SLL  = 5'b00101;
  localparam logic [4:0] OPC_SRL  = 5'b00110;
  localparam logic [4:0] OPC_LD   = 5'b00111;
  localparam logic [4:0] OPC_ST   = 5'b01000;
  localparam logic [4:0] OPC_BEQ  = 5'b01001;
  localparam logic [4:0] OPC_B    = 5'b01010;
  localparam logic [4:0] OPC_NOP  = 5'b01111;
  localparam logic [4:0] OPC_HALT = 5'b11111;

  localparam int CTRL_ALU_OP_W = 3;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_AND = 3'd0;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_OR  = 3'd1;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_XOR = 3'd2;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_ADD = 3'd3;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_SUB = 3'd4;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_SLL = 3'd5;
  localparam logic [CTRL_ALU_OP_W-1:0] ALU_SRL = 3'd6;

  // ctrl bundle: [0] reg_we [1] mem_rd [2] mem_wr [3] branch [4] jump [5] alu_imm [8:6] alu_op
  localparam int CTRL_REG_WE     = 0;
  localparam int CTRL_MEM_RD     = 1;
  localparam int CTRL_MEM_WR     = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_ALU_IMM    = 5;
  localparam int CTRL_ALU_OP_LSB = 6;
  localparam int CTRL_W          = 9;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_WAIT     = 3'd1,
    ST_VPU_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALTED   = 3'd4
  } state_e;

  function automatic logic [CTRL_W-1:0] ctrl_word(
    input logic                     reg_we,
    input logic                     mem_rd,
    input logic                     mem_wr,
    input logic                     branch,
    input logic                     jump,
    input logic                     alu_imm,
    input logic [CTRL_ALU_OP_W-1:0] alu_op
  );
    logic [CTRL_W-1:0] w;
    w                                          = '0;
    w[CTRL_REG_WE]                             = reg_we;
    w[CTRL_MEM_RD]                             = mem_rd;
    w[CTRL_MEM_WR]                             = mem_wr;
    w[CTRL_BRANCH]                             = branch;
    w[CTRL_JUMP]                               = jump;
    w[CTRL_ALU_IMM]                            = alu_imm;
    w[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W]        = alu_op;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Bundle between fetch/decode, the sequencer and the VPU array. The sequencer
// uses the slave view; the upstream/bench side uses the master view.
interface ctrl_sequencer_if
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 5,
  parameter int TIMER_W = 16,
  parameter int NUM_VPU = 2,
  parameter int VCH_W   = (NUM_VPU > 1) ? $clog2(NUM_VPU) : 1
);
  logic               instr_valid;
  logic [OPC_W-1:0]   opcode;
  logic               x_bit;
  logic [TIMER_W-1:0] wait_time;
  logic [VCH_W-1:0]   vpu_sel;
  logic [NUM_VPU-1:0] vpu_done;
  logic [CTRL_W-1:0]  ctrl;
  logic [NUM_VPU-1:0] vpu_start;
  logic [NUM_VPU-1:0] vpu_busy;
  logic               stall;
  logic               halted;
  logic [2:0]         state;

  modport master (
    output instr_valid, opcode, x_bit, wait_time, vpu_sel, vpu_done,
    input  ctrl, vpu_start, vpu_busy, stall, halted, state
  );

  modport slave (
    input  instr_valid, opcode, x_bit, wait_time, vpu_sel, vpu_done,
    output ctrl, vpu_start, vpu_busy, stall, halted, state
  );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode/x_bit decode into the scalar ctrl bundle, plus
// NOP/HALT/VPU classification. Anything outside the scalar set, NOP and HALT is a VPU op.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic              x_bit,
  output logic [CTRL_W-1:0] ctrl,
  output logic              is_nop,
  output logic              is_halt,
  output logic              is_vpu
);

  // x_bit selects the immediate operand on ALU ops and the link write on B.
  always_comb begin
    ctrl    = '0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    is_vpu  = 1'b0;
    case (opcode)
      OPC_W'(OPC_AND):  ctrl = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, x_bit, ALU_AND);
      OPC_W'(OPC_OR):   ctrl = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, x_bit, ALU_OR);
      OPC_W'(OPC_XOR):  ctrl = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, x_bit, ALU_XOR);
      OPC_W'(OPC_ADD):  ctrl = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, x_bit, ALU_ADD);
      OPC_W'(OPC_SUB):  ctrl = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, x_bit, ALU_SUB);
      OPC_W'(OPC_SLL):  ctrl = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, x_bit, ALU_SLL);
      OPC_W'(OPC_SRL):  ctrl = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, x_bit, ALU_SRL);
      OPC_W'(OPC_LD):   ctrl = ctrl_word(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  ALU_ADD);
      OPC_W'(OPC_ST):   ctrl = ctrl_word(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  ALU_ADD);
      OPC_W'(OPC_BEQ):  ctrl = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  ALU_SUB);
      OPC_W'(OPC_B):    ctrl = ctrl_word(x_bit, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_AND);
      OPC_W'(OPC_NOP):  is_nop  = 1'b1;
      OPC_W'(OPC_HALT): is_halt = 1'b1;
      default:          is_vpu  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: zero-cycle scalar decode, NOP/WAIT timer,
// per-channel VPU busy scoreboard and HALT drain, driven by one FSM.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 5,
  parameter int TIMER_W = 16,
  parameter int NUM_VPU = 2,
  parameter int VCH_W   = (NUM_VPU > 1) ? $clog2(NUM_VPU) : 1
) (
  input  logic            clk,
  input  logic            rst,
  ctrl_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [VCH_W-1:0]   vch_q, vch_d;
  logic [NUM_VPU-1:0] vpu_busy_q, vpu_busy_d;
  logic               halted_q, halted_d;

  logic [CTRL_W-1:0]  dec_ctrl_s;
  logic               is_nop_s, is_halt_s, is_vpu_s;
  logic [NUM_VPU-1:0] sel_oh_s, vch_oh_s;
  logic               sel_busy_s, vch_busy_s;
  logic [NUM_VPU-1:0] vpu_start_s;
  logic               stall_s;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode  (bus.opcode),
    .x_bit   (bus.x_bit),
    .ctrl    (dec_ctrl_s),
    .is_nop  (is_nop_s),
    .is_halt (is_halt_s),
    .is_vpu  (is_vpu_s)
  );

  // One-hot views of the requested and latched channel; out-of-range selects match nothing.
  always_comb begin
    sel_oh_s = '0;
    vch_oh_s = '0;
    for (int i = 0; i < NUM_VPU; i++) begin
      sel_oh_s[i] = (bus.vpu_sel == VCH_W'(i));
      vch_oh_s[i] = (vch_q == VCH_W'(i));
    end
  end

  assign sel_busy_s = |(vpu_busy_q & sel_oh_s);
  assign vch_busy_s = |(vpu_busy_q & vch_oh_s);

  // Next-state, timer, channel latch, start pulses and stall.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    vch_d       = vch_q;
    vpu_start_s = '0;
    stall_s     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.instr_valid) begin
          if (is_nop_s) begin
            if (bus.wait_time != '0) begin
              stall_s = 1'b1;
              timer_d = bus.wait_time - TIMER_W'(1);
              state_d = ST_WAIT;
            end else begin
              stall_s = 1'b0;
            end
          end else if (is_halt_s) begin
            stall_s = 1'b1;
            state_d = (vpu_busy_q == '0) ? ST_HALTED : ST_DRAIN;
          end else if (is_vpu_s) begin
            if (sel_busy_s) begin
              stall_s = 1'b1;
              vch_d   = bus.vpu_sel;
              state_d = ST_VPU_WAIT;
            end else begin
              vpu_start_s = sel_oh_s;
            end
          end else begin
            stall_s = 1'b0;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (timer_q != '0) begin
          stall_s = 1'b1;
          timer_d = timer_q - TIMER_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_VPU_WAIT: begin
        if (vch_busy_s) begin
          stall_s = 1'b1;
        end else begin
          vpu_start_s = vch_oh_s;
          state_d     = ST_RUN;
        end
      end
      ST_DRAIN: begin
        stall_s = 1'b1;
        if (vpu_busy_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        stall_s = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
  end

  // Scoreboard: a start on the same cycle as a done leaves the channel busy.
  always_comb begin
    vpu_busy_d = (vpu_busy_q & ~bus.vpu_done) | vpu_start_s;
    halted_d   = halted_q | (state_d == ST_HALTED);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      timer_q    <= '0;
      vch_q      <= '0;
      vpu_busy_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      vch_q      <= vch_d;
      vpu_busy_q <= vpu_busy_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.ctrl      = (!rst && (state_q == ST_RUN) && bus.instr_valid) ? dec_ctrl_s : '0;
  assign bus.vpu_start = rst ? '0 : vpu_start_s;
  assign bus.stall     = rst ? 1'b0 : stall_s;
  assign bus.vpu_busy  = vpu_busy_q;
  assign bus.halted    = halted_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios followed by random
// instruction streams, checked against a transaction-level timing model.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  localparam int NV = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_sequencer_if #(.OPC_W(5), .TIMER_W(16), .NUM_VPU(NV), .VCH_W(1)) bus ();

  ctrl_sequencer #(.OPC_W(5), .TIMER_W(16), .NUM_VPU(NV), .VCH_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  // Model of each channel's latest job: issue cycle and the cycle its done pulse fires.
  int job_start [NV];
  int job_end   [NV];
  logic [NV-1:0] extra_done = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_ctrl(input int op, input logic x);
    int we = 0, rd = 0, wr = 0, br = 0, jmp = 0, imm = 0, alu = 0;
    if (op <= 6) begin
      we = 1; alu = op; imm = int'(x);
    end else if (op == 7) begin
      we = 1; rd = 1; alu = 3; imm = 1;
    end else if (op == 8) begin
      wr = 1; alu = 3; imm = 1;
    end else if (op == 9) begin
      br = 1; alu = 4;
    end else if (op == 10) begin
      jmp = 1; we = int'(x);
    end
    return 9'(we + 2 * rd + 4 * wr + 8 * br + 16 * jmp + 32 * imm + 64 * alu);
  endfunction

  function automatic logic [NV-1:0] busy_model(input int t);
    logic [NV-1:0] b;
    b = '0;
    for (int c = 0; c < NV; c++) b[c] = (job_start[c] < t) && (job_end[c] >= t);
    return b;
  endfunction

  function automatic logic [4:0] rand_vpu_op();
    int r;
    r = int'($urandom_range(0, 18));
    return (r < 4) ? 5'(11 + r) : 5'(12 + r);
  endfunction

  task automatic clear_model();
    for (int c = 0; c < NV; c++) begin
      job_start[c] = -10;
      job_end[c]   = -10;
    end
  endtask

  // One clock: drive done pulses, check every output at negedge, advance.
  task automatic cycle_check(input string tag, input logic exp_stall, input logic [NV-1:0] exp_start,
                             input logic [8:0] exp_ctrl, input logic exp_halted, input int exp_state = -1);
    logic [NV-1:0] d;
    for (int c = 0; c < NV; c++) d[c] = (job_end[c] == cyc) || extra_done[c];
    bus.vpu_done = d;
    @(negedge clk);
    check({tag, ":stall"},  32'(bus.stall),     32'(exp_stall));
    check({tag, ":start"},  32'(bus.vpu_start), 32'(exp_start));
    check({tag, ":ctrl"},   32'(bus.ctrl),      32'(exp_ctrl));
    check({tag, ":busy"},   32'(bus.vpu_busy),  32'(busy_model(cyc)));
    check({tag, ":halted"}, 32'(bus.halted),    32'(exp_halted));
    if (exp_state >= 0) check({tag, ":state"}, 32'(bus.state), 32'(exp_state));
    @(posedge clk);
    #1;
    cyc++;
    extra_done = '0;
  endtask

  task automatic do_reset(input string tag);
    rst             = 1'b1;
    bus.vpu_done    = '0;
    extra_done      = '0;
    bus.instr_valid = 1'b1;
    bus.opcode      = OPC_AND;
    bus.x_bit       = 1'b1;
    bus.vpu_sel     = 1'b0;
    @(negedge clk);
    check({tag, ":rst_ctrl"},  32'(bus.ctrl),      32'd0);
    check({tag, ":rst_start"}, 32'(bus.vpu_start), 32'd0);
    check({tag, ":rst_stall"}, 32'(bus.stall),     32'd0);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    clear_model();
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check({tag, ":state"},  32'(bus.state),    32'(ST_RUN));
    check({tag, ":busy"},   32'(bus.vpu_busy), 32'd0);
    check({tag, ":halted"}, 32'(bus.halted),   32'd0);
    check({tag, ":stall"},  32'(bus.stall),    32'd0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_idle();
    bus.instr_valid = 1'b0;
    bus.opcode      = 5'($urandom_range(0, 31));
    cycle_check("idle", 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_scalar(input int op, input logic x);
    bus.instr_valid = 1'b1;
    bus.opcode      = 5'(op);
    bus.x_bit       = x;
    bus.wait_time   = 16'($urandom_range(0, 65535));
    bus.vpu_sel     = 1'($urandom_range(0, 1));
    cycle_check("scalar", 1'b0, '0, ref_ctrl(op, x), 1'b0);
  endtask

  task automatic do_nop(input int n);
    bus.instr_valid = 1'b1;
    bus.opcode      = OPC_NOP;
    bus.x_bit       = 1'($urandom_range(0, 1));
    bus.wait_time   = 16'(n);
    for (int i = 0; i < n; i++) cycle_check("nop_stall", 1'b1, '0, '0, 1'b0);
    cycle_check("nop_retire", 1'b0, '0, '0, 1'b0);
  endtask

  // A VPU op starts once its channel has been free for a cycle: max(issue, done+1).
  task automatic do_vpu(input logic [4:0] op, input int ch, input int lat);
    int s;
    logic [NV-1:0] m;
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.vpu_sel     = 1'(ch);
    bus.wait_time   = 16'($urandom_range(0, 65535));
    s = (job_end[ch] + 1 > cyc) ? job_end[ch] + 1 : cyc;
    while (cyc < s) cycle_check("vpu_stall", 1'b1, '0, '0, 1'b0);
    m     = '0;
    m[ch] = 1'b1;
    cycle_check("vpu_start", 1'b0, m, '0, 1'b0);
    job_start[ch] = s;
    job_end[ch]   = s + lat;
  endtask

  task automatic drain_idle();
    for (int c = 0; c < NV; c++) while (job_end[c] >= cyc) do_idle();
  endtask

  // HALT stalls until every channel is free (cycle z); halted appears one cycle later.
  task automatic do_halt();
    int k, z;
    k = cyc;
    z = cyc;
    for (int c = 0; c < NV; c++) if (job_end[c] + 1 > z) z = job_end[c] + 1;
    bus.instr_valid = 1'b1;
    bus.opcode      = OPC_HALT;
    while (cyc <= z) begin
      if (cyc == z && z > k) cycle_check("drain", 1'b1, '0, '0, 1'b0, int'(ST_DRAIN));
      else cycle_check("halt_stall", 1'b1, '0, '0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.opcode      = (i == 0) ? OPC_ADD : rand_vpu_op();
      cycle_check("halted", 1'b1, '0, '0, 1'b1, int'(ST_HALTED));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.opcode      = '0;
    bus.x_bit       = 1'b0;
    bus.wait_time   = '0;
    bus.vpu_sel     = '0;
    bus.vpu_done    = '0;
    clear_model();

    do_reset("reset0");
    do_nop(3);
    do_nop(0);
    do_scalar(3, 1'b1);
    do_scalar(10, 1'b1);
    do_scalar(7, 1'b0);

    do_vpu(5'd11, 0, 4);
    do_vpu(5'd20, 0, 2);
    drain_idle();

    do_vpu(5'd12, 0, 5);
    do_vpu(5'd13, 1, 5);
    do_idle();
    drain_idle();

    extra_done = 2'b01;
    do_vpu(5'd30, 0, 3);
    extra_done = 2'b10;
    do_idle();
    drain_idle();

    do_vpu(5'd16, 1, 6);
    do_halt();
    do_reset("reset_halted");

    bus.instr_valid = 1'b1;
    bus.opcode      = OPC_NOP;
    bus.wait_time   = 16'd100;
    for (int i = 0; i < 5; i++) cycle_check("wait100", 1'b1, '0, '0, 1'b0, (i == 0) ? int'(ST_RUN) : int'(ST_WAIT));
    do_reset("reset_wait");
    do_nop(2);
    do_nop(1);

    for (int i = 0; i < 120; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 3)      do_scalar(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
      else if (kind < 5) do_nop(int'($urandom_range(0, 4)));
      else if (kind < 8) do_vpu(rand_vpu_op(), int'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
      else               do_idle();
    end
    do_halt();
    do_reset("reset_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
